// File: rtl/memory_responder_if.sv
// ============================================================================
//  Module      : memory_responder_if
//  Description : Request/response bundle between a line requester and the
//                memory responder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface memory_responder_if #(
    parameter int LINE_WORDS = 4
);
    logic                       i_req_valid;
    logic                       o_req_ready;
    logic                       i_req_write;
    logic [31:0]                i_req_address;
    logic [LINE_WORDS*32-1:0]   i_req_data;
    logic                       o_resp_valid;
    logic                       o_resp_write;
    logic [LINE_WORDS*32-1:0]   o_resp_data;
    logic                       i_resp_ready;

    modport master (
        output i_req_valid, i_req_write, i_req_address, i_req_data, i_resp_ready,
        input  o_req_ready, o_resp_valid, o_resp_write, o_resp_data
    );

    modport slave (
        input  i_req_valid, i_req_write, i_req_address, i_req_data, i_resp_ready,
        output o_req_ready, o_resp_valid, o_resp_write, o_resp_data
    );
endinterface

`default_nettype wire

// File: rtl/memory_responder.sv
// ============================================================================
//  Module      : memory_responder
//  Description : Single-outstanding line read/write responder with a fixed
//                access latency over a word-addressed backing store.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module memory_responder #(
    parameter int LINE_WORDS = 4,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 3
) (
    input  wire logic           i_clock,
    input  wire logic           i_reset,
    memory_responder_if.slave   bus
);

    localparam int c_IDX_W  = $clog2(MEM_WORDS);
    localparam int c_CNT_W  = $clog2(LATENCY + 1);
    localparam int c_LINE_W = LINE_WORDS * 32;
    localparam logic [c_IDX_W-1:0] c_LINE_MASK = c_IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_IDX_W-1:0]     r_base;
    logic                   r_write;
    logic [c_LINE_W-1:0]    r_data;
    logic                   r_resp_valid;
    logic                   r_resp_write;
    logic [c_LINE_W-1:0]    r_resp_data;

    logic [31:0]            r_mem [MEM_WORDS];

    logic [c_IDX_W-1:0]     w_base;
    logic                   w_accept;
    logic                   w_access;
    logic                   w_unused_addr;

    // Byte offset and bits above the store depth are discarded, so addresses wrap.
    assign w_base        = bus.i_req_address[c_IDX_W+1:2] & ~c_LINE_MASK;
    assign w_unused_addr = ^{bus.i_req_address[31:c_IDX_W+2], bus.i_req_address[1:0]};

    assign bus.o_req_ready  = (r_state == ST_IDLE) && !i_reset;
    assign bus.o_resp_valid = r_resp_valid;
    assign bus.o_resp_write = r_resp_write;
    assign bus.o_resp_data  = r_resp_data;

    assign w_accept = bus.i_req_valid && bus.o_req_ready;
    assign w_access = !i_reset && (r_state == ST_WAIT) && (r_count == c_CNT_W'(1));

    always_ff @(posedge i_clock) begin
        if (w_access && r_write) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                r_mem[r_base + c_IDX_W'(k)] <= r_data[32*k +: 32];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_write <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_base  <= w_base;
                        r_write <= bus.i_req_write;
                        r_data  <= bus.i_req_data;
                        r_count <= c_CNT_W'(LATENCY);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_count <= r_count - c_CNT_W'(1);
                    if (w_access) begin
                        r_state      <= ST_RESPOND;
                        r_resp_valid <= 1'b1;
                        r_resp_write <= r_write;
                        for (int k = 0; k < LINE_WORDS; k++) begin
                            r_resp_data[32*k +: 32] <= r_write ? 32'h0
                                                               : r_mem[r_base + c_IDX_W'(k)];
                        end
                    end
                end
                ST_RESPOND: begin
                    if (bus.i_resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_responder.sv
// ============================================================================
//  Module      : tb_memory_responder
//  Description : Directed self-checking bench for memory_responder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_memory_responder;

    localparam int LW  = 4;
    localparam int MW  = 1024;
    localparam int LAT = 3;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    memory_responder_if #(.LINE_WORDS(LW)) bus ();

    memory_responder #(
        .LINE_WORDS (LW),
        .MEM_WORDS  (MW),
        .LATENCY    (LAT)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic wr, input logic [31:0] addr,
                        input logic [LW*32-1:0] data, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.i_req_write   = wr;
        bus.i_req_address = addr;
        bus.i_req_data    = data;
        bus.i_req_valid   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.i_req_valid = 1'b0;
    endtask

    task automatic get_resp(output bit ok, output int cyc, output logic w,
                            output logic [LW*32-1:0] d);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.o_resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        w = bus.o_resp_write;
        d = bus.o_resp_data;
    endtask

    task automatic consume();
        bus.i_resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.i_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.o_req_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready_low: got %b want 0", bus.o_req_ready);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({bus.o_resp_valid, bus.o_resp_write, bus.o_req_ready} !== 3'b001 ||
            bus.o_resp_data !== '0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b write=%b ready=%b data=%h want 0 0 1 0",
                     bus.o_resp_valid, bus.o_resp_write, bus.o_req_ready, bus.o_resp_data);
        end
    endtask

    task automatic test_write_read();
        bit ok_s, ok_r; int cyc; logic w; logic [LW*32-1:0] d;
        logic [LW*32-1:0] line = {32'h44, 32'h33, 32'h22, 32'h11};
        send(1'b1, 32'h0000_0040, line, ok_s);
        get_resp(ok_r, cyc, w, d);
        n_vec++;
        if (!ok_s || !ok_r || w !== 1'b1 || d !== '0) begin
            n_err++; $display("FAIL write_ack: got ok=%b/%b write=%b data=%h want 1/1 1 0", ok_s, ok_r, w, d);
        end
        consume();
        send(1'b0, 32'h0000_0048, '0, ok_s);
        get_resp(ok_r, cyc, w, d);
        n_vec++;
        if (!ok_r || w !== 1'b0 || d !== line) begin
            n_err++; $display("FAIL read_after_write: got write=%b data=%h want 0 %h", w, d, line);
        end
        consume();
    endtask

    task automatic test_latency();
        bit ok_s, ok_r; int cyc; logic w; logic [LW*32-1:0] d;
        send(1'b0, 32'h0000_0044, '0, ok_s);
        get_resp(ok_r, cyc, w, d);
        n_vec++;
        if (!ok_r || cyc !== LAT + 1) begin
            n_err++; $display("FAIL latency: got first-valid cycle %0d want %0d", cyc, LAT + 1);
        end
        consume();
        @(negedge clk);
        n_vec++;
        if (bus.o_resp_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
            n_err++; $display("FAIL single_response: got valid=%b ready=%b want 0 1",
                              bus.o_resp_valid, bus.o_req_ready);
        end
    endtask

    task automatic test_backpressure();
        bit ok_s, ok_r; int cyc; logic w; logic [LW*32-1:0] d;
        int unstable = 0;
        send(1'b0, 32'h0000_0040, '0, ok_s);
        get_resp(ok_r, cyc, w, d);
        bus.i_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.o_resp_valid !== 1'b1 || bus.o_resp_data !== d ||
                bus.o_resp_write !== w || bus.o_req_ready !== 1'b0) unstable++;
        end
        bus.i_req_valid = 1'b0;
        n_vec++;
        if (!ok_r || unstable !== 0 || d !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
            n_err++; $display("FAIL hold_stable: got %0d unstable cycles data=%h want 0 and written line",
                              unstable, d);
        end
        consume();
        @(negedge clk);
        n_vec++;
        if (bus.o_resp_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
            n_err++; $display("FAIL release_to_idle: got valid=%b ready=%b want 0 1",
                              bus.o_resp_valid, bus.o_req_ready);
        end
    endtask

    task automatic test_wrap();
        bit ok_s, ok_r; int cyc; logic w; logic [LW*32-1:0] d;
        logic [LW*32-1:0] line = {32'hDEAD_0003, 32'hBEEF_0002, 32'hCAFE_0001, 32'hF00D_0000};
        send(1'b1, 32'h0000_1000, line, ok_s);
        get_resp(ok_r, cyc, w, d);
        consume();
        send(1'b0, 32'h0000_0000, '0, ok_s);
        get_resp(ok_r, cyc, w, d);
        n_vec++;
        if (!ok_r || d !== line) begin
            n_err++; $display("FAIL address_wrap: got %h want %h", d, line);
        end
        consume();
    endtask

    task automatic test_reset_in_wait();
        bit ok_s, ok_r; int cyc; logic w; logic [LW*32-1:0] d;
        int seen = 0;
        logic [LW*32-1:0] p = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        send(1'b1, 32'h0000_0080, p, ok_s);
        get_resp(ok_r, cyc, w, d);
        consume();
        send(1'b1, 32'h0000_0084, {4{32'h5555_AAAA}}, ok_s);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.o_req_ready !== 1'b1) begin
            n_err++; $display("FAIL ready_after_wait_reset: got %b want 1", bus.o_req_ready);
        end
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            if (bus.o_resp_valid !== 1'b0) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++; $display("FAIL dropped_request: got %0d valid cycles want 0", seen);
        end
        send(1'b0, 32'h0000_0080, '0, ok_s);
        get_resp(ok_r, cyc, w, d);
        n_vec++;
        if (!ok_r || d !== p) begin
            n_err++; $display("FAIL write_suppressed: got %h want %h", d, p);
        end
        consume();
    endtask

    task automatic test_reset_in_respond();
        bit ok_s, ok_r; int cyc; logic w; logic [LW*32-1:0] d;
        send(1'b0, 32'h0000_0080, '0, ok_s);
        get_resp(ok_r, cyc, w, d);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (!ok_r || bus.o_resp_valid !== 1'b0 || bus.o_resp_write !== 1'b0 ||
            bus.o_resp_data !== '0 || bus.o_req_ready !== 1'b1) begin
            n_err++; $display("FAIL respond_reset: got valid=%b write=%b ready=%b data=%h want 0 0 1 0",
                              bus.o_resp_valid, bus.o_resp_write, bus.o_req_ready, bus.o_resp_data);
        end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int accepts = 0;
        int overlap = 0;
        @(negedge clk);
        bus.i_req_write   = 1'b0;
        bus.i_req_address = 32'h0000_0040;
        bus.i_req_valid   = 1'b1;
        bus.i_resp_ready  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.o_req_ready && bus.o_resp_valid) overlap++;
            if (bus.o_req_ready) begin
                if (last >= 0) begin
                    n_vec++;
                    if (c - last !== LAT + 2) begin
                        n_err++; $display("FAIL accept_spacing: got %0d want %0d", c - last, LAT + 2);
                    end
                end
                last = c;
                accepts++;
            end
            @(negedge clk);
        end
        bus.i_req_valid = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        bus.i_resp_ready = 1'b0;
        n_vec++;
        if (accepts !== 8 || overlap !== 0) begin
            n_err++; $display("FAIL back_to_back: got accepts=%0d overlap=%0d want 8 0", accepts, overlap);
        end
        n_vec++;
        if (bus.o_resp_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
            n_err++; $display("FAIL drain_idle: got valid=%b ready=%b want 0 1",
                              bus.o_resp_valid, bus.o_req_ready);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst               = 1'b1;
        bus.i_req_valid   = 1'b0;
        bus.i_req_write   = 1'b0;
        bus.i_req_address = '0;
        bus.i_req_data    = '0;
        bus.i_resp_ready  = 1'b0;
        test_reset();
        test_write_read();
        test_latency();
        test_backpressure();
        test_wrap();
        test_reset_in_wait();
        test_reset_in_respond();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter LINE_WORDS, default 4, 32-bit words per line transfer (power of two, >=1).
REQ-002 Parameter MEM_WORDS, default 1024, backing storage depth in 32-bit words (power of two, multiple of LINE_WORDS).
REQ-003 Parameter LATENCY, default 3, cycles from request acceptance to response valid (>=1).
REQ-004 i_clock  input  1  sole clock; all state updates on rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_req_valid  input  1  requester presents a line request.
REQ-007 o_req_ready  output  1  responder can accept a request this cycle.
REQ-008 i_req_write  input  1  1 = line write, 0 = line read.
REQ-009 i_req_address  input  32  byte address of the line.
REQ-010 i_req_data  input  LINE_WORDS*32  write line; word k in bits [32k+31:32k].
REQ-011 o_resp_valid  output  1  response (read data or write acknowledge) is presented.
REQ-012 o_resp_write  output  1  echo of i_req_write for the current response.
REQ-013 o_resp_data  output  LINE_WORDS*32  read line, same packing as i_req_data; all zero for write responses.
REQ-014 i_resp_ready  input  1  requester consumes the response this cycle.

Function
REQ-015 The block SHALL implement states IDLE, WAIT and RESPOND, one request in flight at a time.
REQ-016 o_req_ready SHALL be 1 exactly when state is IDLE and i_reset is 0.
REQ-017 A request SHALL be accepted on an edge where i_req_valid and o_req_ready are both 1; address, write flag and data latched; down-counter loaded with LATENCY; state -> WAIT.
REQ-018 In WAIT the counter SHALL decrement each cycle; on the edge where it goes 1 -> 0 the access SHALL execute and state -> RESPOND.
REQ-019 With acceptance on edge N, o_resp_valid SHALL first be 1 in the cycle after edge N+LATENCY (LATENCY=1: cycle immediately after acceptance cycle).
REQ-020 Base word index SHALL be (i_req_address >> 2) mod MEM_WORDS with low log2(LINE_WORDS) bits cleared; address bits [1:0] and intra-line offset ignored; out-of-range addresses wrap.
REQ-021 Read: o_resp_data word k SHALL equal storage[base+k] sampled at the access edge.
REQ-022 Write: storage[base+k] SHALL be updated with word k at the access edge; o_resp_data SHALL be zero.
REQ-023 In RESPOND, o_resp_valid, o_resp_write and o_resp_data SHALL hold stable until an edge with i_resp_ready=1, then state -> IDLE and o_resp_valid -> 0.
REQ-024 i_resp_ready while o_resp_valid=0 SHALL have no effect; i_req_valid outside IDLE SHALL be ignored (not queued).
REQ-025 Response consumption and next acceptance SHALL NOT occur in the same cycle; minimum request spacing is LATENCY+2 cycles.
REQ-026 Reads following a write to the same line SHALL return the written data.

Reset
REQ-027 On an edge with i_reset=1: state -> IDLE, counter -> 0, o_resp_valid -> 0, o_resp_write -> 0, o_resp_data -> 0; i_reset has priority over every other event on that edge.
REQ-028 Reset in WAIT SHALL drop the request; a pending write not yet executed SHALL NOT modify storage.
REQ-029 Reset in RESPOND SHALL drop the response without requiring i_resp_ready.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-031 Write addr 0x0000_0040, data {0x44,0x33,0x22,0x11}, then read 0x0000_0048 -> read response words 0..3 = 0x11,0x22,0x33,0x44, o_resp_write=0.
REQ-032 LATENCY=3, request accepted on edge 10 -> o_resp_valid first 1 in the cycle after edge 13, exactly once per request.
REQ-033 Hold i_resp_ready=0 for 5 cycles in RESPOND -> o_resp_valid and o_resp_data stable for all 5, o_req_ready=0; ready pulse -> IDLE next cycle.
REQ-034 MEM_WORDS=1024, write to byte address 0x0000_1000 -> subsequent read of 0x0000_0000 returns that data (wrap).
REQ-035 Write accepted, i_reset pulsed one cycle in WAIT -> no response, o_req_ready=1 after reset, read of same line returns prior contents.
REQ-036 i_req_valid held high continuously with i_resp_ready=1 -> accepts spaced exactly LATENCY+2 cycles apart, never while o_resp_valid=1.
